delay_buffer_mc: RTL

DELAY_BUFFER_MC -- requirements
Module: delay_buffer_mc

---
 rtl/delay_buf_pkg.sv | 21 ++
 rtl/delay_lane.sv | 50 +++++
 rtl/delay_buffer_mc.sv | 81 ++++++++
 3 files changed

// File: rtl/delay_buf_pkg.sv
// Shared defaults and the effective-delay clamp for the multi-channel delay buffer.
package delay_buf_pkg;

  localparam int CHANNELS_DEF = 4;
  localparam int DEPTH_DEF    = 8;
  localparam int BITS_DEF     = 64;

  typedef int unsigned uint_t;

  // A programmed delay of 0 behaves as a single register; anything past DEPTH saturates.
  function automatic uint_t clamp_delay(input uint_t delay, input uint_t depth);
    if (delay == 0) begin
      return 1;
    end else if (delay > depth) begin
      return depth;
    end else begin
      return delay;
    end
  endfunction

endpackage

// File: rtl/delay_lane.sv
// One data lane: DEPTH x BITS ring storage, write port and a registered, zero-forced read.
module delay_lane
  import delay_buf_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int BITS  = BITS_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            clr_i,
  input  logic            adv_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [AW-1:0]   raddr_i,
  input  logic            bypass_i,
  input  logic            load_i,
  input  logic [BITS-1:0] d_i,
  output logic [BITS-1:0] q_o
);

  logic [BITS-1:0] mem_q [DEPTH];
  logic [BITS-1:0] q_q;
  logic [BITS-1:0] rd_data;

  // Storage is deliberately not reset; q is forced to zero whenever the new q_valid is low.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= d_i;
    end
  end

  // With a one-cycle delay the slot being read is the one written this edge, so take d directly.
  always_comb begin
    rd_data = mem_q[raddr_i];
    if (bypass_i) begin
      rd_data = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      q_q <= '0;
    end else if (adv_i) begin
      q_q <= load_i ? rd_data : '0;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/delay_buffer_mc.sv
// Multi-channel programmable delay buffer; shared write pointer, fill count and q_valid.
// Defining DELAY_BUF_FILL_EN adds the fill_cnt output port.
module delay_buffer_mc
  import delay_buf_pkg::*;
#(
  parameter  int CHANNELS = CHANNELS_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int BITS     = BITS_DEF,
  localparam int DW       = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic [DW-1:0]            delay,
  input  logic [CHANNELS*BITS-1:0] d,
  output logic [CHANNELS*BITS-1:0] q,
  output logic                     q_valid
`ifdef DELAY_BUF_FILL_EN
  ,
  output logic [DW-1:0]            fill_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q;
  logic [DW-1:0] fill_q, fill_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] de;
  logic [AW-1:0] raddr;
  logic          adv, clr;

  assign clr = rst | flush;
  assign adv = en & ~flush & ~rst;
  assign de  = DW'(clamp_delay(uint_t'(delay), uint_t'(DEPTH)));

  // Read slot is De-1 entries behind the slot written this edge.
  always_comb begin
    fill_d  = (fill_q == DW'(DEPTH)) ? fill_q : fill_q + DW'(1);
    valid_d = (fill_d >= de);
    raddr   = wptr_q - AW'(de - DW'(1));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr_q  <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else if (adv) begin
      wptr_q  <= wptr_q + AW'(1);
      fill_q  <= fill_d;
      valid_q <= valid_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    delay_lane #(
      .DEPTH(DEPTH),
      .BITS (BITS)
    ) u_lane (
      .clk     (clk),
      .clr_i   (clr),
      .adv_i   (adv),
      .we_i    (adv),
      .waddr_i (wptr_q),
      .raddr_i (raddr),
      .bypass_i(de == DW'(1)),
      .load_i  (valid_d),
      .d_i     (d[c*BITS +: BITS]),
      .q_o     (q[c*BITS +: BITS])
    );
  end

  assign q_valid = valid_q;

`ifdef DELAY_BUF_FILL_EN
  assign fill_cnt = fill_q;
`endif

endmodule
